// File: rtl/video_timing_pkg.sv
// Shared mode constants, colour type and test-pattern bar table for the video timing generator.
package video_timing_pkg;

  // 640x480@60, 800x525 total
  localparam int unsigned ModeHActive = 640;
  localparam int unsigned ModeHFp     = 16;
  localparam int unsigned ModeHSync   = 96;
  localparam int unsigned ModeHBp     = 48;
  localparam int unsigned ModeVActive = 480;
  localparam int unsigned ModeVFp     = 10;
  localparam int unsigned ModeVSync   = 2;
  localparam int unsigned ModeVBp     = 33;
  localparam logic        ModeHPol    = 1'b0;
  localparam logic        ModeVPol    = 1'b0;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int unsigned NumBars = 8;

  // Left to right: white, yellow, cyan, green, magenta, red, blue, black
  localparam rgb_t BarColour [NumBars] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

endpackage

// File: rtl/video_timing_delay.sv
// Parameterized shift register with synchronous active-low reset to a fixed value.
module pipe_delay #(
  parameter int unsigned      WIDTH = 1,
  parameter int unsigned      DEPTH = 1,
  parameter logic [WIDTH-1:0] RESET = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] stage_d;
    logic [WIDTH-1:0] stage_q;

    if (i == 0) begin : g_head
      assign stage_d = d_i;
    end else begin : g_tail
      assign stage_d = g_stage[i-1].stage_q;
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        stage_q <= RESET;
      end else begin
        stage_q <= stage_d;
      end
    end
  end

  assign q_o = g_stage[DEPTH-1].stage_q;

endmodule

// File: rtl/video_timing.sv
// Raster timing generator with shader coordinate output and latency-matched video return.
// Define VIDEO_TIMING_TEST_PATTERN_EN to replace shader colour with 8 vertical colour bars.
module video_timing
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = ModeHActive,
  parameter int unsigned H_FP     = ModeHFp,
  parameter int unsigned H_SYNC   = ModeHSync,
  parameter int unsigned H_BP     = ModeHBp,
  parameter int unsigned V_ACTIVE = ModeVActive,
  parameter int unsigned V_FP     = ModeVFp,
  parameter int unsigned V_SYNC   = ModeVSync,
  parameter int unsigned V_BP     = ModeVBp,
  parameter logic        H_POL    = ModeHPol,
  parameter logic        V_POL    = ModeVPol,
  parameter int unsigned PIX_LAT  = 1
) (
  input  logic        pxl_clk,
  input  logic        rst_n,
  output logic [9:0]  x,
  output logic [9:0]  y,
  input  logic [7:0]  r,
  input  logic [7:0]  g,
  input  logic [7:0]  b,
  output logic        vid_de,
  output logic        vid_hsync,
  output logic        vid_vsync,
  output logic [23:0] vid_rgb,
  output logic        vid_sof
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW       = $clog2(H_TOTAL);
  localparam int unsigned VW       = $clog2(V_TOTAL);
  localparam int unsigned PayloadW = 14;

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          active, hs, vs, sof;

  always_comb begin
    h_cnt_d = h_cnt_q + HW'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == HW'(H_TOTAL - 1)) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == VW'(V_TOTAL - 1)) ? '0 : v_cnt_q + VW'(1);
    end
  end

  always_ff @(posedge pxl_clk) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign active = (h_cnt_q < HW'(H_ACTIVE)) && (v_cnt_q < VW'(V_ACTIVE));
  assign hs     = (h_cnt_q >= HW'(H_ACTIVE + H_FP)) &&
                  (h_cnt_q <  HW'(H_ACTIVE + H_FP + H_SYNC));
  assign vs     = (v_cnt_q >= VW'(V_ACTIVE + V_FP)) &&
                  (v_cnt_q <  VW'(V_ACTIVE + V_FP + V_SYNC));
  assign sof    = (h_cnt_q == '0) && (v_cnt_q == '0);

  // Blanked coordinates read as 0 so the shader never sees an out-of-range position
  assign x = active ? 10'(h_cnt_q) : '0;
  assign y = active ? 10'(v_cnt_q) : '0;

  logic [PayloadW-1:0] pipe_in, pipe_out;
  logic                del_active, del_hs, del_vs, del_sof;
  logic [9:0]          del_x;

  assign pipe_in = {active, hs, vs, sof, x};

  pipe_delay #(
    .WIDTH (PayloadW),
    .DEPTH (PIX_LAT),
    .RESET (PayloadW'(0))
  ) u_pipe (
    .clk_i  (pxl_clk),
    .rst_ni (rst_n),
    .d_i    (pipe_in),
    .q_o    (pipe_out)
  );

  assign {del_active, del_hs, del_vs, del_sof, del_x} = pipe_out;

  rgb_t pix;

`ifdef VIDEO_TIMING_TEST_PATTERN_EN
  localparam int unsigned BarW = H_ACTIVE / NumBars;
  logic [2:0] bar_idx;
  logic       unused_shader;
  assign bar_idx       = 3'(del_x / 10'(BarW));
  assign pix           = BarColour[bar_idx];
  assign unused_shader = ^{r, g, b};
`else
  logic unused_del_x;
  assign pix          = {r, g, b};
  assign unused_del_x = ^del_x;
`endif

  logic vid_de_q, vid_hsync_q, vid_vsync_q, vid_sof_q;
  rgb_t vid_rgb_q;

  always_ff @(posedge pxl_clk) begin
    if (!rst_n) begin
      vid_de_q    <= 1'b0;
      vid_hsync_q <= ~H_POL;
      vid_vsync_q <= ~V_POL;
      vid_rgb_q   <= '0;
      vid_sof_q   <= 1'b0;
    end else begin
      vid_de_q    <= del_active;
      vid_hsync_q <= del_hs ? H_POL : ~H_POL;
      vid_vsync_q <= del_vs ? V_POL : ~V_POL;
      vid_rgb_q   <= del_active ? pix : '0;
      vid_sof_q   <= del_sof;
    end
  end

  assign vid_de    = vid_de_q;
  assign vid_hsync = vid_hsync_q;
  assign vid_vsync = vid_vsync_q;
  assign vid_rgb   = vid_rgb_q;
  assign vid_sof   = vid_sof_q;

endmodule

// File: tb/tb_video_timing.sv
// Bench: default-mode instance checked against a vector table and a raster model; a small-mode
// PIX_LAT=3 instance with random shader keys and random reset pulses checked against the model.
module tb_video_timing;

  localparam int NCyc   = 12000;
  localparam int HaB    = 16;
  localparam int HfB    = 2;
  localparam int HsB    = 3;
  localparam int HbB    = 3;
  localparam int VaB    = 6;
  localparam int VfB    = 1;
  localparam int VsB    = 2;
  localparam int VbB    = 1;
  localparam int FrameB = (HaB + HfB + HsB + HbB) * (VaB + VfB + VsB + VbB);

  typedef struct {
    int          cyc;
    logic        de;
    logic        hs;
    logic        vs;
    logic        sof;
    logic [23:0] rgb;
    logic [9:0]  x;
    logic [9:0]  y;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_a_n, rst_b_n;
  logic [9:0]  x_a, y_a, x_b, y_b;
  logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b;
  logic        de_a, hs_a, vs_a, sof_a, de_b, hs_b, vs_b, sof_b;
  logic [23:0] rgb_a, rgb_b;
  logic [7:0]  kg, kb;
  logic [23:0] sb1, sb2, sb3;
  logic [47:0] bund_a, bund_b;

  int   compared = 0;
  int   mismatched = 0;
  int   cnt_a, cnt_b;
  vec_t tab[$];
  int   first_de_b = -1;
  bit   wait_sof = 1'b0;
  bit   det_done = 1'b0;
  int   de_run = 0;
  int   hs_run = 0;
  int   hs_first = -1;

  always #5 clk = ~clk;

  video_timing u_dut_a (
    .pxl_clk   (clk),
    .rst_n     (rst_a_n),
    .x         (x_a),
    .y         (y_a),
    .r         (r_a),
    .g         (g_a),
    .b         (b_a),
    .vid_de    (de_a),
    .vid_hsync (hs_a),
    .vid_vsync (vs_a),
    .vid_rgb   (rgb_a),
    .vid_sof   (sof_a)
  );

  video_timing #(
    .H_ACTIVE (HaB),
    .H_FP     (HfB),
    .H_SYNC   (HsB),
    .H_BP     (HbB),
    .V_ACTIVE (VaB),
    .V_FP     (VfB),
    .V_SYNC   (VsB),
    .V_BP     (VbB),
    .H_POL    (1'b1),
    .V_POL    (1'b0),
    .PIX_LAT  (3)
  ) u_dut_b (
    .pxl_clk   (clk),
    .rst_n     (rst_b_n),
    .x         (x_b),
    .y         (y_b),
    .r         (r_b),
    .g         (g_b),
    .b         (b_b),
    .vid_de    (de_b),
    .vid_hsync (hs_b),
    .vid_vsync (vs_b),
    .vid_rgb   (rgb_b),
    .vid_sof   (sof_b)
  );

  // Shader stubs: one register for instance A, three for instance B
  always_ff @(posedge clk) begin
    {r_a, g_a, b_a} <= {x_a[7:0], y_a[7:0], 8'h5A};
    sb1 <= {x_b[7:0], y_b[7:0] ^ kg, (x_b[7:0] + y_b[7:0]) ^ kb};
    sb2 <= sb1;
    sb3 <= sb2;
  end
  assign {r_b, g_b, b_b} = sb3;

  function automatic logic [23:0] colour(input int shader, input int h, input int v,
                                         input int ha);
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
    case (h / (ha / 8))
      0:       return 24'hFFFFFF;
      1:       return 24'hFFFF00;
      2:       return 24'h00FFFF;
      3:       return 24'h00FF00;
      4:       return 24'hFF00FF;
      5:       return 24'hFF0000;
      6:       return 24'h0000FF;
      default: return (shader < 0 || v < 0) ? 24'hFFFFFF : 24'h000000;
    endcase
`else
    if (ha <= 0) return 24'h0;
    if (shader == 0) return {8'(h), 8'(v), 8'h5A};
    return {8'(h), 8'(v) ^ kg, 8'(h + v) ^ kb};
`endif
  endfunction

  // p = clock edges since reset release; outputs show raster position p - lat.
  // Packed as {de, hsync, vsync, sof, rgb, x, y}.
  function automatic logic [47:0] model(input int p, input int lat, input int ha, input int hf,
                                        input int hs, input int hb, input int va, input int vf,
                                        input int vs, input int vb, input logic hpol,
                                        input logic vpol, input int shader);
    int ht, vt, hc, vc, q, h, v;
    logic de, hsy, vsy, sof;
    logic [23:0] rgb;
    logic [9:0] xo, yo;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    hc = p % ht;
    vc = (p / ht) % vt;
    xo = (hc < ha && vc < va) ? 10'(hc) : 10'd0;
    yo = (hc < ha && vc < va) ? 10'(vc) : 10'd0;
    if (p < lat) begin
      de = 1'b0; hsy = ~hpol; vsy = ~vpol; sof = 1'b0; rgb = 24'h0;
    end else begin
      q   = p - lat;
      h   = q % ht;
      v   = (q / ht) % vt;
      de  = (h < ha) && (v < va);
      hsy = (h >= ha + hf && h < ha + hf + hs) ? hpol : ~hpol;
      vsy = (v >= va + vf && v < va + vf + vs) ? vpol : ~vpol;
      sof = (q % (ht * vt)) == 0;
      rgb = de ? colour(shader, h, v, ha) : 24'h0;
    end
    return {de, hsy, vsy, sof, rgb, xo, yo};
  endfunction

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input int cyc, input logic de, input logic hs, input logic vs,
                     input logic sof, input logic [23:0] rgb_def, input logic [23:0] rgb_pat,
                     input logic [9:0] xv, input logic [9:0] yv);
    vec_t v;
    v.cyc = cyc; v.de = de; v.hs = hs; v.vs = vs; v.sof = sof; v.x = xv; v.y = yv;
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
    v.rgb = rgb_pat;
`else
    v.rgb = rgb_def;
`endif
    tab.push_back(v);
  endtask

  initial begin
    kg = 8'($urandom);
    kb = 8'($urandom);
    //  cyc  de hs vs sof  shader rgb   pattern rgb  x    y
    add(0,    0, 1, 1, 0, 24'h000000, 24'h000000, 0,   0);
    add(1,    0, 1, 1, 0, 24'h000000, 24'h000000, 1,   0);
    add(2,    1, 1, 1, 1, 24'h00005A, 24'hFFFFFF, 2,   0);
    add(3,    1, 1, 1, 0, 24'h01005A, 24'hFFFFFF, 3,   0);
    add(87,   1, 1, 1, 0, 24'h55005A, 24'hFFFF00, 87,  0);
    add(641,  1, 1, 1, 0, 24'h7F005A, 24'h000000, 0,   0);
    add(642,  0, 1, 1, 0, 24'h000000, 24'h000000, 0,   0);
    add(657,  0, 1, 1, 0, 24'h000000, 24'h000000, 0,   0);
    add(658,  0, 0, 1, 0, 24'h000000, 24'h000000, 0,   0);
    add(753,  0, 0, 1, 0, 24'h000000, 24'h000000, 0,   0);
    add(754,  0, 1, 1, 0, 24'h000000, 24'h000000, 0,   0);
    add(802,  1, 1, 1, 0, 24'h00015A, 24'hFFFFFF, 2,   1);
    add(3041, 1, 1, 1, 0, 24'h7F035A, 24'h000000, 0,   0);
    add(3042, 0, 1, 1, 0, 24'h000000, 24'h000000, 0,   0);

    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    repeat (10) @(negedge clk);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    cnt_a = 0;
    cnt_b = 0;

    for (int n = 0; n < NCyc; n++) begin
      bund_a = {de_a, hs_a, vs_a, sof_a, rgb_a, x_a, y_a};
      bund_b = {de_b, hs_b, vs_b, sof_b, rgb_b, x_b, y_b};
      check($sformatf("stream_a cyc %0d", cnt_a), bund_a,
            model(cnt_a, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 0));
      check($sformatf("stream_b n %0d pos %0d", n, cnt_b), bund_b,
            model(cnt_b, 4, HaB, HfB, HsB, HbB, VaB, VfB, VsB, VbB, 1'b1, 1'b0, 1));

      foreach (tab[i]) begin
        if (tab[i].cyc == cnt_a) begin
          check($sformatf("vec cyc %0d", tab[i].cyc), bund_a,
                {tab[i].de, tab[i].hs, tab[i].vs, tab[i].sof, tab[i].rgb, tab[i].x, tab[i].y});
        end
      end

      // Line 1 of instance A: DE run length and hsync placement
      if (cnt_a >= 802 && cnt_a < 1602) begin
        de_run += int'(de_a);
        if (!hs_a) begin
          hs_run++;
          if (hs_first < 0) hs_first = cnt_a;
        end
      end
      if (cnt_a == 1602) begin
        check("line1 de count", 48'(de_run), 48'd640);
        check("line1 hsync width", 48'(hs_run), 48'd96);
        check("line1 hsync start", 48'(hs_first), 48'd1458);
      end

      if (de_b && first_de_b < 0) begin
        first_de_b = cnt_b;
        check("b first de cycle", 48'(cnt_b), 48'd4);
      end

      if (wait_sof && sof_b) begin
        check("b sof after reset", 48'(cnt_b), 48'd4);
        wait_sof = 1'b0;
      end else if (wait_sof && cnt_b > 8) begin
        check("b sof after reset timeout", 48'(cnt_b), 48'd4);
        wait_sof = 1'b0;
      end

      // One-cycle reset pulses on instance B: one inside hsync, others random
      if (!rst_b_n) begin
        rst_b_n = 1'b1;
      end else if (!det_done && n > 3000 && (cnt_b % FrameB) == 4 * 24 + 19) begin
        rst_b_n  = 1'b0;
        det_done = 1'b1;
        wait_sof = 1'b1;
      end else if (n > 500 && $urandom_range(0, 799) == 0) begin
        rst_b_n = 1'b0;
      end

      @(posedge clk);
      cnt_a++;
      cnt_b = rst_b_n ? cnt_b + 1 : 0;
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
